// File: rtl/vliw_issue_ctrl.sv
// Two-slot VLIW issue controller: accepts R/S bundles, tracks load-use hazards,
// sequences memory waits with timeout, control-flow flushes and exceptions.
module vliw_issue_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        exc_clear,
  input  logic        bundle_valid,
  input  logic [4:0]  R_opcode,
  input  logic [4:0]  S_opcode,
  input  logic [4:0]  R_rs1,
  input  logic [4:0]  R_rs2,
  input  logic [4:0]  S_rd,
  input  logic        branch_taken,
  input  logic        mem_ack,
  output logic        bundle_ready,
  output logic        issue_R,
  output logic        issue_S,
  output logic        PC_Write,
  output logic        mem_req,
  output logic        mem_we,
  output logic        flush,
  output logic        stall,
  output logic        exception,
  output logic [15:0] issue_count
);

  localparam logic [4:0] OP_ADD    = 5'b00011;
  localparam logic [4:0] OP_SUB    = 5'b01000;
  localparam logic [4:0] OP_LOAD   = 5'b01010;
  localparam logic [4:0] OP_STORE  = 5'b01011;
  localparam logic [4:0] OP_JUMP   = 5'b11100;
  localparam logic [4:0] OP_BRANCH = 5'b11010;
  localparam logic [4:0] TMO_LAST  = 5'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_EXC      = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        load_pend_r;
  logic [4:0]  load_rd_r;
  logic [4:0]  tmo_cnt_r;
  logic [15:0] issue_count_r;
  logic        issue_r_r, issue_s_r, pc_write_r;
  logic        mem_req_r, mem_we_r, flush_r, exception_r;

  logic r_legal_s, s_legal_s, legal_s;
  logic is_load_s, is_store_s, is_jump_s, is_branch_s;
  logic hazard_s, ready_s, accept_s, tmo_last_s;

  // Bundle decode, hazard detection and handshake
  always_comb begin
    r_legal_s   = (R_opcode == OP_ADD) || (R_opcode == OP_SUB);
    is_load_s   = (S_opcode == OP_LOAD);
    is_store_s  = (S_opcode == OP_STORE);
    is_jump_s   = (S_opcode == OP_JUMP);
    is_branch_s = (S_opcode == OP_BRANCH);
    s_legal_s   = is_load_s || is_store_s || is_jump_s || is_branch_s;
    legal_s     = r_legal_s && s_legal_s;
    hazard_s    = (state_r == ST_ISSUE) && bundle_valid && load_pend_r &&
                  (load_rd_r != 5'd0) &&
                  ((load_rd_r == R_rs1) || (load_rd_r == R_rs2));
    ready_s     = (state_r == ST_ISSUE) && legal_s && !hazard_s;
    accept_s    = bundle_valid && ready_s;
    tmo_last_s  = (tmo_cnt_r == TMO_LAST);
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_ISSUE;
        else       state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (bundle_valid && !legal_s)                 state_nxt_s = ST_EXC;
        else if (accept_s && (is_load_s || is_store_s)) state_nxt_s = ST_MEM_WAIT;
        else if (accept_s && (is_jump_s || (is_branch_s && branch_taken)))
                                                      state_nxt_s = ST_FLUSH;
        else                                          state_nxt_s = ST_ISSUE;
      end
      ST_MEM_WAIT: begin
        // An ack on the last allowed cycle still completes normally
        if (mem_ack)         state_nxt_s = ST_ISSUE;
        else if (tmo_last_s) state_nxt_s = ST_EXC;
        else                 state_nxt_s = ST_MEM_WAIT;
      end
      ST_FLUSH: state_nxt_s = ST_ISSUE;
      ST_EXC: begin
        if (exc_clear) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_EXC;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, hazard tracker, timeout counter and issue counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      load_pend_r   <= 1'b0;
      load_rd_r     <= 5'd0;
      tmo_cnt_r     <= 5'd0;
      issue_count_r <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        load_pend_r <= is_load_s;
        load_rd_r   <= S_rd;
      end else if (hazard_s || (state_r == ST_EXC)) begin
        load_pend_r <= 1'b0;
        load_rd_r   <= 5'd0;
      end else begin
        load_pend_r <= load_pend_r;
        load_rd_r   <= load_rd_r;
      end
      if ((state_r == ST_MEM_WAIT) && (state_nxt_s == ST_MEM_WAIT))
        tmo_cnt_r <= tmo_cnt_r + 5'd1;
      else
        tmo_cnt_r <= 5'd0;
      if (accept_s) issue_count_r <= issue_count_r + 16'd1;
      else          issue_count_r <= issue_count_r;
    end
  end

  // Registered pulse and status outputs derived from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_r_r   <= 1'b0;
      issue_s_r   <= 1'b0;
      pc_write_r  <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      flush_r     <= 1'b0;
      exception_r <= 1'b0;
    end else begin
      issue_r_r   <= accept_s;
      issue_s_r   <= accept_s;
      pc_write_r  <= accept_s;
      mem_req_r   <= (state_nxt_s == ST_MEM_WAIT);
      mem_we_r    <= (state_nxt_s == ST_MEM_WAIT) && (accept_s ? is_store_s : mem_we_r);
      flush_r     <= (state_nxt_s == ST_FLUSH);
      exception_r <= (state_nxt_s == ST_EXC);
    end
  end

  assign bundle_ready = ready_s;
  assign stall        = hazard_s;
  assign issue_R      = issue_r_r;
  assign issue_S      = issue_s_r;
  assign PC_Write     = pc_write_r;
  assign mem_req      = mem_req_r;
  assign mem_we       = mem_we_r;
  assign flush        = flush_r;
  assign exception    = exception_r;
  assign issue_count  = issue_count_r;

endmodule

// File: tb/tb_vliw_issue_ctrl.sv
// Directed self-checking bench for vliw_issue_ctrl; output flags are packed
// into one word so each cycle is checked against a hand-computed constant.
module tb_vliw_issue_ctrl;

  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b01000, BAD = 5'b11111;
  localparam logic [4:0] LD = 5'b01010, ST = 5'b01011, JMP = 5'b11100, BR = 5'b11010;

  localparam logic [15:0] RDY  = 16'h0100, IR  = 16'h0080, IS = 16'h0040;
  localparam logic [15:0] PCW  = 16'h0020, MREQ = 16'h0010, MWE = 16'h0008;
  localparam logic [15:0] FL   = 16'h0004, STL = 16'h0002, EXC = 16'h0001;
  localparam logic [15:0] ISS  = IR | IS | PCW;
  localparam logic [15:0] NONE = 16'h0000;

  logic clk = 1'b0;
  logic rst, start, exc_clear, bundle_valid, branch_taken, mem_ack;
  logic [4:0] R_opcode, S_opcode, R_rs1, R_rs2, S_rd;
  logic bundle_ready, issue_R, issue_S, PC_Write, mem_req, mem_we;
  logic flush, stall, exception;
  logic [15:0] issue_count;
  logic [15:0] outs_s;

  int checks = 0;
  int failures = 0;

  vliw_issue_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .exc_clear(exc_clear),
    .bundle_valid(bundle_valid), .R_opcode(R_opcode), .S_opcode(S_opcode),
    .R_rs1(R_rs1), .R_rs2(R_rs2), .S_rd(S_rd), .branch_taken(branch_taken),
    .mem_ack(mem_ack), .bundle_ready(bundle_ready), .issue_R(issue_R),
    .issue_S(issue_S), .PC_Write(PC_Write), .mem_req(mem_req), .mem_we(mem_we),
    .flush(flush), .stall(stall), .exception(exception), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  assign outs_s = {7'd0, bundle_ready, issue_R, issue_S, PC_Write, mem_req,
                   mem_we, flush, stall, exception};

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_bundle();
    bundle_valid = 1'b0;
    R_opcode = 5'd0; S_opcode = 5'd0;
    R_rs1 = 5'd0; R_rs2 = 5'd0; S_rd = 5'd0;
    branch_taken = 1'b0;
  endtask

  task automatic bundle(input logic [4:0] r_op, input logic [4:0] s_op,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic tk);
    bundle_valid = 1'b1;
    R_opcode = r_op; S_opcode = s_op;
    R_rs1 = rs1; R_rs2 = rs2; S_rd = rd;
    branch_taken = tk;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; exc_clear = 1'b0; mem_ack = 1'b0;
    no_bundle();
    tick(); tick();
    chk("reset_outs", outs_s, NONE);
    chk("reset_count", issue_count, 16'd0);
    rst = 1'b0;

    // add/load rd=3, ack after two wait cycles
    start = 1'b1; tick(); start = 1'b0; #1;
    chk("issue_idle", outs_s, NONE);
    bundle(ADD, LD, 5'd1, 5'd2, 5'd3, 1'b0); #1;
    chk("load_ready", outs_s, RDY);
    tick(); no_bundle(); #1;
    chk("load_n1", outs_s, ISS | MREQ);
    chk("load_cnt", issue_count, 16'd1);
    tick(); #1;
    chk("load_n2", outs_s, MREQ);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0; #1;
    chk("load_n3", outs_s, NONE);

    // load rd=5 then sub rs1=5: one stall cycle
    bundle(ADD, LD, 5'd1, 5'd2, 5'd5, 1'b0); #1;
    chk("ld5_ready", outs_s, RDY);
    tick(); no_bundle(); mem_ack = 1'b1; #1;
    chk("ld5_issue", outs_s, ISS | MREQ);
    tick(); mem_ack = 1'b0; bundle(SUB, BR, 5'd5, 5'd0, 5'd0, 1'b0); #1;
    chk("hazard_stall", outs_s, STL);
    tick(); #1;
    chk("hazard_clear", outs_s, RDY);
    tick(); no_bundle(); #1;
    chk("hazard_accept", outs_s, ISS);
    chk("hazard_cnt", issue_count, 16'd3);

    // load rd=0 then sub rs1=0: no stall
    tick(); bundle(ADD, LD, 5'd1, 5'd2, 5'd0, 1'b0); #1;
    chk("ld0_ready", outs_s, RDY);
    tick(); no_bundle(); mem_ack = 1'b1; #1;
    chk("ld0_issue", outs_s, ISS | MREQ);
    tick(); mem_ack = 1'b0; bundle(SUB, BR, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("rd0_nostall", outs_s, RDY);
    tick(); no_bundle(); #1;
    chk("rd0_accept", outs_s, ISS);
    chk("rd0_cnt", issue_count, 16'd5);

    // illegal R opcode
    tick(); bundle(BAD, LD, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("illegal_ready", outs_s, NONE);
    tick(); no_bundle(); start = 1'b1; #1;
    chk("illegal_exc", outs_s, EXC);
    tick(); start = 1'b0; #1;
    chk("exc_held", outs_s, EXC);
    exc_clear = 1'b1;
    tick(); exc_clear = 1'b0; bundle(ADD, BR, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("exc_to_idle", outs_s, NONE);
    chk("exc_cnt", issue_count, 16'd5);
    no_bundle(); start = 1'b1;
    tick(); start = 1'b0; #1;
    chk("restart", outs_s, NONE);

    // store with no ack: timeout after 16 wait cycles
    bundle(ADD, ST, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("st_ready", outs_s, RDY);
    tick(); no_bundle(); #1;
    chk("st_issue", outs_s, ISS | MREQ | MWE);
    repeat (15) tick();
    chk("st_wait16", outs_s, MREQ | MWE);
    tick();
    chk("st_timeout", outs_s, EXC);
    chk("st_cnt", issue_count, 16'd6);
    exc_clear = 1'b1; tick(); exc_clear = 1'b0;
    start = 1'b1; tick(); start = 1'b0; #1;
    chk("st_restart", outs_s, NONE);

    // store with ack on the final allowed cycle
    bundle(ADD, ST, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    tick(); no_bundle(); #1;
    chk("st2_issue", outs_s, ISS | MREQ | MWE);
    repeat (15) tick();
    mem_ack = 1'b1; #1;
    chk("st2_wait16", outs_s, MREQ | MWE);
    tick(); mem_ack = 1'b0; #1;
    chk("st2_ack_wins", outs_s, NONE);
    chk("st2_cnt", issue_count, 16'd7);

    // jump, taken branch, then back-to-back not-taken branches
    bundle(ADD, JMP, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("jmp_ready", outs_s, RDY);
    tick(); no_bundle(); #1;
    chk("jmp_flush", outs_s, ISS | FL);
    tick(); #1;
    chk("jmp_flush_end", outs_s, NONE);
    bundle(ADD, BR, 5'd0, 5'd0, 5'd0, 1'b1); #1;
    tick(); no_bundle(); #1;
    chk("brt_flush", outs_s, ISS | FL);
    tick(); bundle(ADD, BR, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("brnt_ready", outs_s, RDY);
    tick(); #1;
    chk("brnt_b2b", outs_s, ISS | RDY);
    tick(); no_bundle(); #1;
    chk("brnt_second", outs_s, ISS);
    chk("flow_cnt", issue_count, 16'd11);

    // reset during MEM_WAIT
    tick(); bundle(ADD, LD, 5'd1, 5'd2, 5'd7, 1'b0); #1;
    tick(); no_bundle(); #1;
    chk("mw_entry", outs_s, ISS | MREQ);
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("mw_reset_outs", outs_s, NONE);
    chk("mw_reset_cnt", issue_count, 16'd0);
    bundle(ADD, BR, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("mw_reset_idle", outs_s, NONE);

    // 65536 back-to-back accepts wrap the counter
    no_bundle(); start = 1'b1;
    tick(); start = 1'b0; bundle(ADD, BR, 5'd0, 5'd0, 5'd0, 1'b0); #1;
    chk("wrap_ready", outs_s, RDY);
    repeat (65535) tick();
    chk("wrap_ffff", issue_count, 16'hFFFF);
    tick();
    chk("wrap_zero", issue_count, 16'd0);
    chk("wrap_outs", outs_s, ISS | RDY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
